sda_ptos_tx: RTL

Parametrised parallel-to-serial transmitter that emits a DATA_W-bit word MSB-first on a two-wire (scl/sda) line with start and stop conditions. Upstream logic hands words over through a valid/ready handshake. The SCL rate is divided from the system clock. This is the generalised successor of the fixed 4-bit serial line driver: the word width, the SCL divider and back-to-back framing are all configurable.

---
 rtl/sda_ptos_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sda_ptos_tx.sv
// Parallel-to-serial two-wire (scl/sda) transmitter with start/stop framing, MSB first.
// Optional even parity bit after bit 0 when SDA_PARITY_EN is defined.
module sda_ptos_tx #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned HALF_DIV = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              scl,
    output logic              sda,
    output logic              busy,
    output logic              done
);

`ifdef SDA_PARITY_EN
    localparam int unsigned N = DATA_W + 1;
`else
    localparam int unsigned N = DATA_W;
`endif
    localparam int unsigned PH_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned BC_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(N - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_BIT_LO  = 3'd2;
    localparam logic [2:0] ST_BIT_HI  = 3'd3;
    localparam logic [2:0] ST_STOP_LO = 3'd4;
    localparam logic [2:0] ST_STOP_HI = 3'd5;
    localparam logic [2:0] ST_GAP     = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic            scl_q, scl_d;
    logic            sda_q, sda_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            phase_last;
    logic            accept;

    assign phase_last = (phase_q == PH_LAST);
    assign accept     = (state_q == ST_IDLE) && data_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_last ? '0 : phase_q + PH_W'(1);
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (accept) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
`ifdef SDA_PARITY_EN
                    shreg_d   = {data_in, ^data_in};
`else
                    shreg_d   = data_in;
`endif
                end
            end
            ST_START:   if (phase_last) state_d = ST_BIT_LO;
            ST_BIT_LO:  if (phase_last) state_d = ST_BIT_HI;
            ST_BIT_HI: begin
                if (phase_last) begin
                    if (bit_cnt_q == BC_LAST) begin
                        state_d = ST_STOP_LO;
                    end else begin
                        state_d   = ST_BIT_LO;
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        shreg_d   = shreg_q << 1;
                    end
                end
            end
            ST_STOP_LO: if (phase_last) state_d = ST_STOP_HI;
            ST_STOP_HI: if (phase_last) state_d = ST_GAP;
            ST_GAP:     if (phase_last) state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_d)
            ST_START:   begin scl_d = 1'b1; sda_d = 1'b0;           end
            ST_BIT_LO:  begin scl_d = 1'b0; sda_d = shreg_d[N-1];   end
            ST_BIT_HI:  begin scl_d = 1'b1; sda_d = shreg_d[N-1];   end
            ST_STOP_LO: begin scl_d = 1'b0; sda_d = 1'b0;           end
            ST_STOP_HI: begin scl_d = 1'b1; sda_d = 1'b0;           end
            default:    begin scl_d = 1'b1; sda_d = 1'b1;           end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_GAP) && (phase_d == PH_LAST);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign scl        = scl_q;
    assign sda        = sda_q;
    assign data_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
